// File: rtl/uart_i2c_cmd_framer_if.sv
// Bus bundle between the command framer and its neighbours.
// The UART receiver, the I2C master and the UART transmitter all attach here.
// master: the framer side. slave: the environment side (receiver, I2C master, transmitter).
interface uart_i2c_cmd_framer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic        cmd_rw;
  logic [7:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [15:0] rsp_rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        frame_err;

  modport master (
    input  rx_data, rx_valid, cmd_ready, rsp_valid, rsp_nack, rsp_rdata, tx_busy,
    output cmd_valid, cmd_addr, cmd_rw, cmd_reg, cmd_wdata, tx_data, tx_start,
           busy, frame_err
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready, rsp_valid, rsp_nack, rsp_rdata, tx_busy,
    input  cmd_valid, cmd_addr, cmd_rw, cmd_reg, cmd_wdata, tx_data, tx_start,
           busy, frame_err
  );
endinterface

// File: rtl/uart_i2c_cmd_framer.sv
// Command framer for the UART-to-I2C bridge.
// Four UART bytes become one I2C command. The I2C master's response goes back to the
// UART transmitter as a status byte. Reads also return two data bytes.
// Every output comes straight from a flop.
module uart_i2c_cmd_framer #(
  parameter int CLK_FREQ      = 100000000,
  parameter int UART_BPS      = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  uart_i2c_cmd_framer_if.master bus
);

  localparam int TIMEOUT_CYCLES = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COLLECT   = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_RSP  = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_SEND_WAIT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [6:0]    cmd_addr_q, cmd_addr_d;
  logic          cmd_rw_q, cmd_rw_d;
  logic [7:0]    cmd_reg_q, cmd_reg_d;
  logic [15:0]   cmd_wdata_q, cmd_wdata_d;
  logic [7:0]    rsp0_q, rsp0_d, rsp1_q, rsp1_d, rsp2_q, rsp2_d;
  logic [1:0]    rsp_cnt_q, rsp_cnt_d;
  logic [1:0]    guard_q, guard_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;

  // Next-state logic for the framing FSM, the response queue and the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp0_d      = rsp0_q;
    rsp1_d      = rsp1_q;
    rsp2_d      = rsp2_q;
    rsp_cnt_d   = rsp_cnt_q;
    guard_d     = guard_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          b0_d    = bus.rx_data;
          cnt_d   = 2'd1;
          timer_d = '0;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (bus.rx_valid) begin
          timer_d = '0;
          case (cnt_q)
            2'd1: begin
              b1_d  = bus.rx_data;
              cnt_d = 2'd2;
            end
            2'd2: begin
              b2_d  = bus.rx_data;
              cnt_d = 2'd3;
            end
            default: begin
              cmd_addr_d  = b0_q[7:1];
              cmd_rw_d    = b0_q[0];
              cmd_reg_d   = b1_q;
              cmd_wdata_d = {b2_q, bus.rx_data};
              cmd_valid_d = 1'b1;
              cnt_d       = 2'd0;
              state_d     = S_ISSUE;
            end
          endcase
        end else if (timer_q == TIMER_MAX) begin
          frame_err_d = 1'b1;
          cnt_d       = 2'd0;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_ISSUE: begin
        if (bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_RSP;
        end
      end

      S_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          if (bus.rsp_nack) begin
            rsp0_d    = 8'hEE;
            rsp1_d    = 8'h00;
            rsp2_d    = 8'h00;
            rsp_cnt_d = 2'd1;
          end else if (cmd_rw_q) begin
            rsp0_d    = 8'h00;
            rsp1_d    = bus.rsp_rdata[15:8];
            rsp2_d    = bus.rsp_rdata[7:0];
            rsp_cnt_d = 2'd3;
          end else begin
            rsp0_d    = 8'h00;
            rsp1_d    = 8'h00;
            rsp2_d    = 8'h00;
            rsp_cnt_d = 2'd1;
          end
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d  = rsp0_q;
          tx_start_d = 1'b1;
          rsp0_d     = rsp1_q;
          rsp1_d     = rsp2_q;
          rsp2_d     = 8'h00;
          rsp_cnt_d  = rsp_cnt_q - 2'd1;
          guard_d    = 2'd2;
          state_d    = S_SEND_WAIT;
        end
      end

      S_SEND_WAIT: begin
        // The transmitter may raise tx_busy late, so it is not trusted right after a start.
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (!bus.tx_busy) begin
          state_d = (rsp_cnt_q != 2'd0) ? S_SEND : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A byte that arrives while a command is in flight has nowhere to go. It is dropped and flagged.
    if (bus.rx_valid && (state_q == S_ISSUE || state_q == S_WAIT_RSP ||
                         state_q == S_SEND  || state_q == S_SEND_WAIT)) begin
      frame_err_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      timer_q     <= '0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      b2_q        <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= 7'h00;
      cmd_rw_q    <= 1'b0;
      cmd_reg_q   <= 8'h00;
      cmd_wdata_q <= 16'h0000;
      rsp0_q      <= 8'h00;
      rsp1_q      <= 8'h00;
      rsp2_q      <= 8'h00;
      rsp_cnt_q   <= 2'd0;
      guard_q     <= 2'd0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_wdata_q <= cmd_wdata_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      rsp2_q      <= rsp2_d;
      rsp_cnt_q   <= rsp_cnt_d;
      guard_q     <= guard_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_rw    = cmd_rw_q;
  assign bus.cmd_reg   = cmd_reg_q;
  assign bus.cmd_wdata = cmd_wdata_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule
